// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if
//   Bundles every signal of the data-cache miss/write controller except the
//   clock and reset.
//   slave  : the controller side (dcache_ctrl). Pipeline, cache-datapath and
//            memory signals come in; stall, load data, array write port,
//            memory request and performance counters go out.
//   master : the environment side (pipeline + cache datapath + memory).
//   Groups : M-stage access (MemReadM, MemWriteM, ALUResultM, WriteDataM),
//            tag-lookup result (Hit0/1, Valid0/1, CacheData),
//            pipeline return (StallM, ReadDataM),
//            array write port (cache_we/way/set/tag/wdata),
//            memory handshake (mem_req/we/addr/wdata/ack/rdata),
//            counters (hit_count, miss_count).
interface dcache_ctrl_if #(
    parameter int NUM_SET = 4,
    parameter int CNT_W   = 32
);
    localparam int SET_BITS = $clog2(NUM_SET);
    localparam int TAG_W    = 32 - SET_BITS - 2;

    logic                MemReadM;
    logic                MemWriteM;
    logic [31:0]         ALUResultM;
    logic [31:0]         WriteDataM;
    logic                Hit0;
    logic                Hit1;
    logic                Valid0;
    logic                Valid1;
    logic [31:0]         CacheData;

    logic                StallM;
    logic [31:0]         ReadDataM;

    logic                cache_we;
    logic                cache_way;
    logic [SET_BITS-1:0] cache_set;
    logic [TAG_W-1:0]    cache_tag;
    logic [31:0]         cache_wdata;

    logic                mem_req;
    logic                mem_we;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_ack;
    logic [31:0]         mem_rdata;

    logic [CNT_W-1:0]    hit_count;
    logic [CNT_W-1:0]    miss_count;

    modport slave (
        input  MemReadM, MemWriteM, ALUResultM, WriteDataM,
        input  Hit0, Hit1, Valid0, Valid1, CacheData,
        output StallM, ReadDataM,
        output cache_we, cache_way, cache_set, cache_tag, cache_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output hit_count, miss_count
    );

    modport master (
        output MemReadM, MemWriteM, ALUResultM, WriteDataM,
        output Hit0, Hit1, Valid0, Valid1, CacheData,
        input  StallM, ReadDataM,
        input  cache_we, cache_way, cache_set, cache_tag, cache_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl
//   Miss and write-through controller for a 2-way set-associative data cache
//   sitting in the M stage. Classifies each access as load hit, load miss or
//   store, stalls the pipeline while memory is busy, refills one word on a
//   load miss, writes stores through to memory (no allocate on store miss),
//   keeps one LRU bit per set and drives the cache array write port.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-low reset
//     bus : dcache_ctrl_if.slave (pipeline, datapath, memory and counters)
module dcache_ctrl #(
    parameter int NUM_SET = 4,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    dcache_ctrl_if.slave bus
);
    localparam int SET_BITS = $clog2(NUM_SET);
    localparam int TAG_W    = 32 - SET_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_FILL    = 2'd2,
        S_WR_MEM  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [NUM_SET-1:0]  r_lru;          // per set: way to evict next
    logic [31:2]         r_addr;         // word address captured in IDLE
    logic [31:0]         r_wdata;        // store data captured in IDLE
    logic [31:0]         r_rdata;        // refill word captured on ack
    logic                r_wr_done;      // store just retired; let pipeline advance
    logic [CNT_W-1:0]    r_hit_count;
    logic [CNT_W-1:0]    r_miss_count;

    logic [SET_BITS-1:0] w_set;
    logic [TAG_W-1:0]    w_tag;
    logic [SET_BITS-1:0] w_r_set;
    logic [TAG_W-1:0]    w_r_tag;
    logic                w_hit;
    logic                w_hit_way;
    logic                w_victim;

    logic                w_stall;
    logic [31:0]         w_rdata_out;
    logic                w_cache_we;
    logic                w_cache_way;
    logic [SET_BITS-1:0] w_cache_set;
    logic [TAG_W-1:0]    w_cache_tag;
    logic [31:0]         w_cache_wdata;
    logic                w_mem_req;
    logic                w_mem_we;
    logic [31:0]         w_mem_addr;
    logic [31:0]         w_mem_wdata;

    logic                w_capture;
    logic                w_refill_load;
    logic                w_wr_done_set;
    logic                w_lru_we;
    logic [SET_BITS-1:0] w_lru_idx;
    logic                w_lru_val;
    logic                w_cnt_hit;
    logic                w_cnt_miss;

    assign w_set     = bus.ALUResultM[SET_BITS+1:2];
    assign w_tag     = bus.ALUResultM[31:SET_BITS+2];
    assign w_r_set   = r_addr[SET_BITS+1:2];
    assign w_r_tag   = r_addr[31:SET_BITS+2];
    assign w_hit     = bus.Hit0 | bus.Hit1;
    assign w_hit_way = ~bus.Hit0;        // way0 wins if both report a hit

    // Fill an empty way first; only evict by LRU when the set is full.
    assign w_victim  = !bus.Valid0 ? 1'b0 :
                       !bus.Valid1 ? 1'b1 : r_lru[w_r_set];

    always_comb begin
        w_state_next  = r_state;
        w_stall       = 1'b0;
        w_rdata_out   = '0;
        w_cache_we    = 1'b0;
        w_cache_way   = 1'b0;
        w_cache_set   = '0;
        w_cache_tag   = '0;
        w_cache_wdata = '0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_addr    = '0;
        w_mem_wdata   = '0;
        w_capture     = 1'b0;
        w_refill_load = 1'b0;
        w_wr_done_set = 1'b0;
        w_lru_we      = 1'b0;
        w_lru_idx     = '0;
        w_lru_val     = 1'b0;
        w_cnt_hit     = 1'b0;
        w_cnt_miss    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The store that just completed is still presented while the
                // pipeline advances past it; do not restart it.
                if (r_wr_done) begin
                    w_stall = 1'b0;
                end else if (bus.MemWriteM) begin
                    w_stall      = 1'b1;
                    w_capture    = 1'b1;
                    w_state_next = S_WR_MEM;
                    if (w_hit) begin
                        w_cache_we    = 1'b1;
                        w_cache_way   = w_hit_way;
                        w_cache_set   = w_set;
                        w_cache_tag   = w_tag;
                        w_cache_wdata = bus.WriteDataM;
                        w_lru_we      = 1'b1;
                        w_lru_idx     = w_set;
                        w_lru_val     = ~w_hit_way;
                    end
                end else if (bus.MemReadM) begin
                    if (w_hit) begin
                        w_rdata_out = bus.CacheData;
                        w_lru_we    = 1'b1;
                        w_lru_idx   = w_set;
                        w_lru_val   = ~w_hit_way;
                        w_cnt_hit   = 1'b1;
                    end else begin
                        w_stall      = 1'b1;
                        w_capture    = 1'b1;
                        w_cnt_miss   = 1'b1;
                        w_state_next = S_RD_MISS;
                    end
                end
            end
            S_RD_MISS: begin
                w_stall    = 1'b1;
                w_mem_req  = 1'b1;
                w_mem_addr = {r_addr, 2'b00};
                if (bus.mem_ack) begin
                    w_refill_load = 1'b1;
                    w_state_next  = S_FILL;
                end
            end
            S_FILL: begin
                w_cache_we    = 1'b1;
                w_cache_way   = w_victim;
                w_cache_set   = w_r_set;
                w_cache_tag   = w_r_tag;
                w_cache_wdata = r_rdata;
                w_lru_we      = 1'b1;
                w_lru_idx     = w_r_set;
                w_lru_val     = ~w_victim;
                w_rdata_out   = r_rdata;
                w_state_next  = S_IDLE;
            end
            S_WR_MEM: begin
                w_stall     = 1'b1;
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = {r_addr, 2'b00};
                w_mem_wdata = r_wdata;
                if (bus.mem_ack) begin
                    w_wr_done_set = 1'b1;
                    w_state_next  = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even though load-hit data
    // and store-hit strobes are otherwise combinational from the inputs.
    assign bus.StallM      = w_stall & rst;
    assign bus.ReadDataM   = rst ? w_rdata_out : '0;
    assign bus.cache_we    = w_cache_we & rst;
    assign bus.cache_way   = w_cache_way & rst;
    assign bus.cache_set   = rst ? w_cache_set : '0;
    assign bus.cache_tag   = rst ? w_cache_tag : '0;
    assign bus.cache_wdata = rst ? w_cache_wdata : '0;
    assign bus.mem_req     = w_mem_req & rst;
    assign bus.mem_we      = w_mem_we & rst;
    assign bus.mem_addr    = rst ? w_mem_addr : '0;
    assign bus.mem_wdata   = rst ? w_mem_wdata : '0;
    assign bus.hit_count   = r_hit_count;
    assign bus.miss_count  = r_miss_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_wr_done    <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_wr_done <= w_wr_done_set;
            if (w_capture) begin
                r_addr  <= bus.ALUResultM[31:2];
                r_wdata <= bus.WriteDataM;
            end
            if (w_refill_load) begin
                r_rdata <= bus.mem_rdata;
            end
            if (w_cnt_hit && (r_hit_count != {CNT_W{1'b1}})) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_cnt_miss && (r_miss_count != {CNT_W{1'b1}})) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SET; gi++) begin : g_lru
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_lru[gi] <= 1'b0;
                end else if (w_lru_we && (w_lru_idx == SET_BITS'(gi))) begin
                    r_lru[gi] <= w_lru_val;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dcache_ctrl_if #(.NUM_SET(4), .CNT_W(32)) bus();

    dcache_ctrl #(.NUM_SET(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic clear_inputs();
        bus.MemReadM   = 1'b0;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = 32'h0;
        bus.WriteDataM = 32'h0;
        bus.Hit0       = 1'b0;
        bus.Hit1       = 1'b0;
        bus.Valid0     = 1'b0;
        bus.Valid1     = 1'b0;
        bus.CacheData  = 32'h0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bus.StallM !== 1'b0 || bus.mem_req !== 1'b0 || bus.cache_we !== 1'b0) begin n_err++; $display("FAIL reset_strobes: stall=%b req=%b we=%b, required 0/0/0", bus.StallM, bus.mem_req, bus.cache_we); end
        n_cmp++; if (bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin n_err++; $display("FAIL reset_counters: hit=%0d miss=%0d, required 0/0", bus.hit_count, bus.miss_count); end
        // start a load miss, then reset in the middle of RD_MISS
        @(negedge clk); rst = 1'b1; bus.MemReadM = 1'b1; bus.ALUResultM = 32'h40; #1;
        n_cmp++; if (bus.StallM !== 1'b1) begin n_err++; $display("FAIL reset_pre_miss_stall: got %b, required 1", bus.StallM); end
        @(negedge clk); #1;
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL reset_pre_rdmiss_req: got %b, required 1", bus.mem_req); end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.StallM !== 1'b0) begin n_err++; $display("FAIL reset_abort: req=%b stall=%b, required 0/0", bus.mem_req, bus.StallM); end
        repeat (2) @(negedge clk);
        @(negedge clk); rst = 1'b1; bus.MemReadM = 1'b0; bus.ALUResultM = 32'h0; #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.StallM !== 1'b0) begin n_err++; $display("FAIL reset_release: req=%b stall=%b, required 0/0", bus.mem_req, bus.StallM); end
        n_cmp++; if (bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin n_err++; $display("FAIL reset_release_counters: hit=%0d miss=%0d, required 0/0", bus.hit_count, bus.miss_count); end
        // late ack must not trigger a fill
        @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0; #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_late_ack_req: got %b, required 0", bus.mem_req); end
        @(negedge clk); bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; #1;
        n_cmp++; if (bus.cache_we !== 1'b0 || bus.StallM !== 1'b0 || bus.ReadDataM !== 32'h0) begin n_err++; $display("FAIL reset_late_ack_ignored: we=%b stall=%b rdata=%h, required 0/0/0", bus.cache_we, bus.StallM, bus.ReadDataM); end
        $display("reset: done, compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_cold_load();
        int stalls = 0;
        @(negedge clk); clear_inputs(); bus.MemReadM = 1'b1; bus.ALUResultM = 32'h10; #1;
        stalls += int'(bus.StallM);
        n_cmp++; if (bus.StallM !== 1'b1 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL cold_detect: stall=%b req=%b, required 1/0", bus.StallM, bus.mem_req); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF; end
            #1;
            stalls += int'(bus.StallM);
            n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h10) begin n_err++; $display("FAIL cold_req_%0d: req=%b we=%b addr=%h, required 1/0/00000010", i, bus.mem_req, bus.mem_we, bus.mem_addr); end
        end
        @(negedge clk); bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; #1;
        n_cmp++; if (bus.StallM !== 1'b0 || bus.ReadDataM !== 32'hDEADBEEF) begin n_err++; $display("FAIL cold_fill_data: stall=%b rdata=%h, required 0/deadbeef", bus.StallM, bus.ReadDataM); end
        n_cmp++; if (bus.cache_we !== 1'b1 || bus.cache_way !== 1'b0 || bus.cache_set !== 2'd0 || bus.cache_tag !== 28'h1 || bus.cache_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL cold_fill_write: we=%b way=%b set=%0d tag=%h wdata=%h, required 1/0/0/1/deadbeef", bus.cache_we, bus.cache_way, bus.cache_set, bus.cache_tag, bus.cache_wdata); end
        n_cmp++; if (stalls !== 4) begin n_err++; $display("FAIL cold_stall_cycles: got %0d, required 4", stalls); end
        @(negedge clk); clear_inputs(); #1;
        n_cmp++; if (bus.miss_count !== 32'd1 || bus.StallM !== 1'b0) begin n_err++; $display("FAIL cold_miss_count: miss=%0d stall=%b, required 1/0", bus.miss_count, bus.StallM); end
        $display("cold_load: addr=00000010 stalls=%0d", stalls);
    endtask

    task automatic test_load_hit();
        @(negedge clk); clear_inputs();
        bus.MemReadM = 1'b1; bus.ALUResultM = 32'h10; bus.Hit0 = 1'b1; bus.Valid0 = 1'b1; bus.CacheData = 32'hDEADBEEF; #1;
        n_cmp++; if (bus.StallM !== 1'b0 || bus.ReadDataM !== 32'hDEADBEEF || bus.mem_req !== 1'b0 || bus.cache_we !== 1'b0) begin n_err++; $display("FAIL load_hit: stall=%b rdata=%h req=%b we=%b, required 0/deadbeef/0/0", bus.StallM, bus.ReadDataM, bus.mem_req, bus.cache_we); end
        @(negedge clk); clear_inputs(); #1;
        n_cmp++; if (bus.hit_count !== 32'd1) begin n_err++; $display("FAIL load_hit_count: got %0d, required 1", bus.hit_count); end
        $display("load_hit: addr=00000010 hit_count=%0d", bus.hit_count);
    endtask

    // Set 0 full: first miss evicts way1 (LRU left at 1 by the hit), second evicts way0.
    task automatic test_victim();
        logic [31:0] addr_t [2] = '{32'h50, 32'h90};
        logic [31:0] data_t [2] = '{32'hCAFEF00D, 32'h0BADF00D};
        logic        way_t  [2] = '{1'b1, 1'b0};
        logic [27:0] tag_t  [2] = '{28'h5, 28'h9};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); clear_inputs();
            bus.MemReadM = 1'b1; bus.ALUResultM = addr_t[k]; bus.Valid0 = 1'b1; bus.Valid1 = 1'b1; #1;
            n_cmp++; if (bus.StallM !== 1'b1) begin n_err++; $display("FAIL victim_detect_%0d: stall=%b, required 1", k, bus.StallM); end
            @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = data_t[k]; #1;
            n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== addr_t[k]) begin n_err++; $display("FAIL victim_req_%0d: req=%b addr=%h, required 1/%h", k, bus.mem_req, bus.mem_addr, addr_t[k]); end
            @(negedge clk); bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; #1;
            n_cmp++; if (bus.cache_we !== 1'b1 || bus.cache_way !== way_t[k] || bus.cache_set !== 2'd0 || bus.cache_tag !== tag_t[k] || bus.ReadDataM !== data_t[k]) begin n_err++; $display("FAIL victim_fill_%0d: we=%b way=%b set=%0d tag=%h rdata=%h, required 1/%b/0/%h/%h", k, bus.cache_we, bus.cache_way, bus.cache_set, bus.cache_tag, bus.ReadDataM, way_t[k], tag_t[k], data_t[k]); end
            $display("victim: addr=%h way=%b tag=%h", addr_t[k], bus.cache_way, bus.cache_tag);
        end
        @(negedge clk); clear_inputs(); #1;
        n_cmp++; if (bus.miss_count !== 32'd3) begin n_err++; $display("FAIL victim_miss_count: got %0d, required 3", bus.miss_count); end
    endtask

    task automatic test_store_hit();
        @(negedge clk); clear_inputs();
        bus.MemWriteM = 1'b1; bus.ALUResultM = 32'h24; bus.WriteDataM = 32'h12345678;
        bus.Hit1 = 1'b1; bus.Valid0 = 1'b1; bus.Valid1 = 1'b1; #1;
        n_cmp++; if (bus.StallM !== 1'b1 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL store_detect: stall=%b req=%b, required 1/0", bus.StallM, bus.mem_req); end
        n_cmp++; if (bus.cache_we !== 1'b1 || bus.cache_way !== 1'b1 || bus.cache_set !== 2'd1 || bus.cache_tag !== 28'h2 || bus.cache_wdata !== 32'h12345678) begin n_err++; $display("FAIL store_cache_write: we=%b way=%b set=%0d tag=%h wdata=%h, required 1/1/1/2/12345678", bus.cache_we, bus.cache_way, bus.cache_set, bus.cache_tag, bus.cache_wdata); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 1) bus.mem_ack = 1'b1;
            #1;
            n_cmp++; if (bus.StallM !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h24 || bus.mem_wdata !== 32'h12345678 || bus.cache_we !== 1'b0) begin n_err++; $display("FAIL store_mem_%0d: stall=%b req=%b we=%b addr=%h wdata=%h cwe=%b, required 1/1/1/00000024/12345678/0", i, bus.StallM, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cache_we); end
        end
        @(negedge clk); bus.mem_ack = 1'b0; #1;
        n_cmp++; if (bus.StallM !== 1'b0 || bus.mem_req !== 1'b0 || bus.cache_we !== 1'b0) begin n_err++; $display("FAIL store_release: stall=%b req=%b we=%b, required 0/0/0", bus.StallM, bus.mem_req, bus.cache_we); end
        @(negedge clk); clear_inputs(); #1;
        n_cmp++; if (bus.hit_count !== 32'd1 || bus.miss_count !== 32'd3) begin n_err++; $display("FAIL store_counters: hit=%0d miss=%0d, required 1/3", bus.hit_count, bus.miss_count); end
        $display("store_hit: addr=00000024 data=12345678");
    endtask

    task automatic test_rw_priority();
        @(negedge clk); clear_inputs();
        bus.MemReadM = 1'b1; bus.MemWriteM = 1'b1; bus.ALUResultM = 32'h08; bus.WriteDataM = 32'hA5A5A5A5; #1;
        n_cmp++; if (bus.StallM !== 1'b1 || bus.cache_we !== 1'b0) begin n_err++; $display("FAIL rw_detect: stall=%b we=%b, required 1/0", bus.StallM, bus.cache_we); end
        @(negedge clk); bus.mem_ack = 1'b1; #1;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h08 || bus.mem_wdata !== 32'hA5A5A5A5) begin n_err++; $display("FAIL rw_store_path: req=%b we=%b addr=%h wdata=%h, required 1/1/00000008/a5a5a5a5", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        @(negedge clk); bus.mem_ack = 1'b0; #1;
        n_cmp++; if (bus.StallM !== 1'b0 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rw_release: stall=%b req=%b, required 0/0", bus.StallM, bus.mem_req); end
        @(negedge clk); clear_inputs(); #1;
        n_cmp++; if (bus.miss_count !== 32'd3 || bus.hit_count !== 32'd1) begin n_err++; $display("FAIL rw_counters: hit=%0d miss=%0d, required 1/3", bus.hit_count, bus.miss_count); end
        $display("rw_priority: addr=00000008 mem_we taken");
    endtask

    task automatic test_back_to_back();
        @(negedge clk); clear_inputs();
        bus.MemReadM = 1'b1; bus.ALUResultM = 32'h10; bus.Hit0 = 1'b1; bus.Valid0 = 1'b1; bus.CacheData = 32'h11111111; #1;
        n_cmp++; if (bus.StallM !== 1'b0 || bus.ReadDataM !== 32'h11111111) begin n_err++; $display("FAIL b2b_hit0: stall=%b rdata=%h, required 0/11111111", bus.StallM, bus.ReadDataM); end
        @(negedge clk);
        bus.ALUResultM = 32'h24; bus.Hit0 = 1'b0; bus.Hit1 = 1'b1; bus.Valid1 = 1'b1; bus.CacheData = 32'h22222222;
        bus.mem_ack = 1'b1; #1;   // stray ack while idle
        n_cmp++; if (bus.StallM !== 1'b0 || bus.ReadDataM !== 32'h22222222) begin n_err++; $display("FAIL b2b_hit1: stall=%b rdata=%h, required 0/22222222", bus.StallM, bus.ReadDataM); end
        @(negedge clk); clear_inputs(); #1;
        n_cmp++; if (bus.hit_count !== 32'd3 || bus.mem_req !== 1'b0 || bus.cache_we !== 1'b0) begin n_err++; $display("FAIL b2b_after: hit=%0d req=%b we=%b, required 3/0/0", bus.hit_count, bus.mem_req, bus.cache_we); end
        $display("back_to_back: hit_count=%0d", bus.hit_count);
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_load_hit();
        test_victim();
        test_store_hit();
        test_rw_priority();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
